// File: rtl/segment_transition_ctrl_pkg.sv
// rtl/segment_transition_ctrl_pkg.sv - shared constants and types for the segment transition controller
package segment_transition_ctrl_pkg;

    localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
    localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

    localparam logic [15:0] REP_INFINITE = '1;

    // Latched segment field is wide enough for up to 256 segments.
    localparam int MAX_SEG_W = 8;

    typedef struct packed {
        logic [MAX_SEG_W-1:0] segment;
        logic [7:0]           mode;
        logic [63:0]          value;
    } seg_req_t;

    typedef enum logic {
        ST_RUN,
        ST_FINISHED
    } seg_state_t;

    function automatic logic mode_is_valid(input logic [7:0] mode);
        return (mode == TRANSITION_MODE_SYNC_IDX)  ||
               (mode == TRANSITION_MODE_SYS_TIME)  ||
               (mode == TRANSITION_MODE_GPIO)      ||
               (mode == TRANSITION_MODE_IMMEDIATE);
    endfunction

endpackage

// File: rtl/segment_transition_ctrl_trigger_eval.sv
// rtl/segment_transition_ctrl_trigger_eval.sv - evaluates the latched transition trigger each cycle
module segment_trigger_eval
    import segment_transition_ctrl_pkg::*;
#(
    parameter int GPIO_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        mode,
    input  logic [63:0]       value,
    input  logic              idx_wrap,
    input  logic [63:0]       sys_time,
    input  logic [GPIO_W-1:0] gpio_in,
    input  logic              finished,
    output logic              fire
);

    localparam int GSEL_W = (GPIO_W > 1) ? $clog2(GPIO_W) : 1;

    logic [GPIO_W-1:0] gpio_prev_q;
    logic [GPIO_W-1:0] gpio_prev_d;
    logic [GPIO_W-1:0] gpio_rise;
    logic [GSEL_W-1:0] gpio_sel;

    always_comb begin
        gpio_prev_d = gpio_in;
        gpio_rise   = gpio_in & ~gpio_prev_q;
        gpio_sel    = value[GSEL_W-1:0];
        fire        = 1'b0;
        case (mode)
            // A finished segment has a halted index counter, so no wrap will come.
            TRANSITION_MODE_SYNC_IDX:  fire = idx_wrap | finished;
            TRANSITION_MODE_SYS_TIME:  fire = (sys_time >= value);
            TRANSITION_MODE_GPIO:      fire = gpio_rise[gpio_sel];
            TRANSITION_MODE_IMMEDIATE: fire = 1'b1;
            default:                   fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_prev_q <= '0;
        end else begin
            gpio_prev_q <= gpio_prev_d;
        end
    end

endmodule

// File: rtl/segment_transition_ctrl.sv
// rtl/segment_transition_ctrl.sv - N-segment swap controller with triggered transitions and repeat counting
module segment_transition_ctrl
    import segment_transition_ctrl_pkg::*;
#(
    parameter int  NUM_SEGMENTS = 4,
    parameter int  REP_W        = $bits(REP_INFINITE),
    parameter int  GPIO_W       = 4,
    localparam int SEG_W        = $clog2(NUM_SEGMENTS)
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              UPDATE,
    input  logic [SEG_W-1:0]                  REQ_RD_SEGMENT,
    input  logic [7:0]                        TRANSITION_MODE,
    input  logic [63:0]                       TRANSITION_VALUE,
    input  logic [NUM_SEGMENTS-1:0][REP_W-1:0] REP,
    input  logic [63:0]                       SYS_TIME,
    input  logic [GPIO_W-1:0]                 GPIO_IN,
    input  logic                              IDX_WRAP,
    output logic [SEG_W-1:0]                  SEGMENT,
    output logic                              STOP,
    output logic                              PENDING,
    output logic                              SWAP,
    output logic                              ERR
);

    seg_state_t       state_q, state_d;
    logic [SEG_W-1:0] segment_q, segment_d;
    logic             pending_q, pending_d;
    logic             swap_q, swap_d;
    logic             err_q, err_d;
    seg_req_t         req_q, req_d;
    logic [REP_W-1:0] loop_cnt_q, loop_cnt_d;

    logic             finished;
    logic             fire;
    logic             upd_ok;
    logic             pend_fire;
    logic [REP_W-1:0] rep_cur;

    assign finished = (state_q == ST_FINISHED);

    segment_trigger_eval #(
        .GPIO_W(GPIO_W)
    ) u_trigger_eval (
        .clk      (CLK),
        .rst      (RST),
        .mode     (req_q.mode),
        .value    (req_q.value),
        .idx_wrap (IDX_WRAP),
        .sys_time (SYS_TIME),
        .gpio_in  (GPIO_IN),
        .finished (finished),
        .fire     (fire)
    );

    always_comb begin
        state_d    = state_q;
        segment_d  = segment_q;
        pending_d  = pending_q;
        req_d      = req_q;
        loop_cnt_d = loop_cnt_q;
        swap_d     = 1'b0;
        rep_cur    = REP[segment_q];

        upd_ok    = UPDATE && mode_is_valid(TRANSITION_MODE) &&
                    (int'(REQ_RD_SEGMENT) < NUM_SEGMENTS);
        err_d     = UPDATE && !upd_ok;
        pend_fire = pending_q && fire && (int'(req_q.segment) < NUM_SEGMENTS);

        // A fresh request always beats a trigger of the older pending one.
        if (upd_ok) begin
            if (TRANSITION_MODE == TRANSITION_MODE_IMMEDIATE) begin
                segment_d = REQ_RD_SEGMENT;
                swap_d    = 1'b1;
                pending_d = 1'b0;
            end else begin
                req_d.segment = MAX_SEG_W'(REQ_RD_SEGMENT);
                req_d.mode    = TRANSITION_MODE;
                req_d.value   = TRANSITION_VALUE;
                pending_d     = 1'b1;
            end
        end else if (pend_fire) begin
            segment_d = req_q.segment[SEG_W-1:0];
            swap_d    = 1'b1;
            pending_d = 1'b0;
        end

        // REP is compared live; >= catches a budget lowered below the count.
        if (swap_d) begin
            state_d    = ST_RUN;
            loop_cnt_d = '0;
        end else if (state_q == ST_RUN && IDX_WRAP && !(&rep_cur)) begin
            if (loop_cnt_q >= rep_cur) begin
                state_d = ST_FINISHED;
            end else begin
                loop_cnt_d = loop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_RUN;
            segment_q  <= '0;
            pending_q  <= 1'b0;
            swap_q     <= 1'b0;
            err_q      <= 1'b0;
            req_q      <= '0;
            loop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            segment_q  <= segment_d;
            pending_q  <= pending_d;
            swap_q     <= swap_d;
            err_q      <= err_d;
            req_q      <= req_d;
            loop_cnt_q <= loop_cnt_d;
        end
    end

    assign SEGMENT = segment_q;
    assign STOP    = finished;
    assign PENDING = pending_q;
    assign SWAP    = swap_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// tb/tb_segment_transition_ctrl.sv - randomized and directed checks against a behavioural model
module tb_segment_transition_ctrl;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int RW = 16;
    localparam int GW = 4;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    UPDATE;
    logic [SW-1:0]           REQ_RD_SEGMENT;
    logic [7:0]              TRANSITION_MODE;
    logic [63:0]             TRANSITION_VALUE;
    logic [NS-1:0][RW-1:0]   REP;
    logic [63:0]             SYS_TIME;
    logic [GW-1:0]           GPIO_IN;
    logic                    IDX_WRAP;
    logic [SW-1:0]           SEGMENT;
    logic                    STOP;
    logic                    PENDING;
    logic                    SWAP;
    logic                    ERR;

    segment_transition_ctrl #(
        .NUM_SEGMENTS(NS),
        .REP_W(RW),
        .GPIO_W(GW)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .UPDATE           (UPDATE),
        .REQ_RD_SEGMENT   (REQ_RD_SEGMENT),
        .TRANSITION_MODE  (TRANSITION_MODE),
        .TRANSITION_VALUE (TRANSITION_VALUE),
        .REP              (REP),
        .SYS_TIME         (SYS_TIME),
        .GPIO_IN          (GPIO_IN),
        .IDX_WRAP         (IDX_WRAP),
        .SEGMENT          (SEGMENT),
        .STOP             (STOP),
        .PENDING          (PENDING),
        .SWAP             (SWAP),
        .ERR              (ERR)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state: what the outputs must be after the next edge.
    int          m_seg;
    bit          m_stop, m_pend, m_swap, m_err;
    int          m_rseg;
    int          m_rmode;
    logic [63:0] m_rval;
    int          m_cnt;
    bit [GW-1:0] m_gprev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_seg = 0; m_stop = 0; m_pend = 0; m_swap = 0; m_err = 0;
        m_rseg = 0; m_rmode = 0; m_rval = 0; m_cnt = 0; m_gprev = '0;
    endtask

    task automatic model_step();
        bit valid, fire, swap;
        int target, rep, gi;
        if (RST) begin
            model_reset();
            return;
        end
        valid = UPDATE && (TRANSITION_MODE inside {8'h00, 8'h01, 8'h02, 8'hFF});
        fire  = 0;
        if (m_pend) begin
            gi = int'(m_rval % GW);
            case (m_rmode)
                0:   fire = IDX_WRAP || m_stop;
                1:   fire = (SYS_TIME >= m_rval);
                2:   fire = GPIO_IN[gi] && !m_gprev[gi];
                255: fire = 1;
                default: fire = 0;
            endcase
        end
        swap = 0;
        target = m_seg;
        if (valid) begin
            if (TRANSITION_MODE == 8'hFF) begin
                swap = 1; target = int'(REQ_RD_SEGMENT); m_pend = 0;
            end else begin
                m_pend = 1; m_rseg = int'(REQ_RD_SEGMENT);
                m_rmode = int'(TRANSITION_MODE); m_rval = TRANSITION_VALUE;
            end
        end else if (fire) begin
            swap = 1; target = m_rseg; m_pend = 0;
        end
        rep = int'(REP[m_seg]);
        if (swap) begin
            m_seg = target; m_cnt = 0; m_stop = 0;
        end else if (!m_stop && IDX_WRAP && rep != 65535) begin
            if (m_cnt >= rep) m_stop = 1;
            else m_cnt++;
        end
        m_swap  = swap;
        m_err   = UPDATE && !valid;
        m_gprev = GPIO_IN;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("model_segment", SEGMENT, m_seg);
        chk("model_stop",    STOP,    m_stop);
        chk("model_pending", PENDING, m_pend);
        chk("model_swap",    SWAP,    m_swap);
        chk("model_err",     ERR,     m_err);
    endtask

    task automatic idle();
        UPDATE = 0; IDX_WRAP = 0;
    endtask

    task automatic req(input int seg, input logic [7:0] mode, input logic [63:0] val);
        UPDATE = 1; REQ_RD_SEGMENT = SW'(seg); TRANSITION_MODE = mode; TRANSITION_VALUE = val;
    endtask

    initial begin
        RST = 1; UPDATE = 0; REQ_RD_SEGMENT = 0; TRANSITION_MODE = 0; TRANSITION_VALUE = 0;
        REP = '1; SYS_TIME = 0; GPIO_IN = 0; IDX_WRAP = 0;
        model_reset();
        tick(); tick();
        RST = 0;
        tick();
        chk("reset_segment", SEGMENT, 0);
        chk("reset_flags", {STOP, PENDING, SWAP, ERR}, 0);

        // IMMEDIATE
        req(2, 8'hFF, 0); tick();
        chk("imm_segment", SEGMENT, 2);
        chk("imm_swap", SWAP, 1);
        chk("imm_pending", PENDING, 0);
        idle(); tick();
        chk("imm_swap_pulse", SWAP, 0);

        // SYNC_IDX: wrap in the UPDATE cycle is ignored
        req(1, 8'h00, 0); IDX_WRAP = 1; tick();
        chk("sync_pending", PENDING, 1);
        chk("sync_first_wrap", SEGMENT, 2);
        idle();
        repeat (4) tick();
        chk("sync_wait", SEGMENT, 2);
        IDX_WRAP = 1; tick();
        chk("sync_segment", SEGMENT, 1);
        chk("sync_swap", SWAP, 1);
        idle(); tick();

        // SYS_TIME ramp
        SYS_TIME = 990; req(3, 8'h01, 1000); tick();
        idle();
        for (int t = 991; t < 1000; t++) begin SYS_TIME = t; tick(); end
        chk("time_before", SEGMENT, 1);
        SYS_TIME = 1000; tick();
        chk("time_segment", SEGMENT, 3);
        chk("time_swap", SWAP, 1);
        // already past
        SYS_TIME = 990; req(0, 8'h01, 5); tick();
        chk("past_t1", SEGMENT, 3);
        idle(); tick();
        chk("past_t2", SEGMENT, 0);

        // Repeats on segment 0
        REP[0] = 2;
        for (int w = 0; w < 3; w++) begin
            IDX_WRAP = 1; tick(); IDX_WRAP = 0; tick();
            if (w == 1) chk("rep_not_yet", STOP, 0);
        end
        chk("rep_stop", STOP, 1);
        IDX_WRAP = 1; tick(); IDX_WRAP = 0; tick();
        chk("rep_4th_stop", STOP, 1);
        chk("rep_4th_seg", SEGMENT, 0);
        req(3, 8'h00, 0); tick();
        chk("fin_pending", PENDING, 1);
        idle(); tick();
        chk("fin_swap_seg", SEGMENT, 3);
        chk("fin_stop_clr", STOP, 0);

        // GPIO trigger on bit 3 only
        GPIO_IN = 0; req(1, 8'h02, 3); tick();
        idle(); GPIO_IN = 4'b0100; tick();
        chk("gpio_other_bit", SEGMENT, 3);
        GPIO_IN = 4'b1100; tick();
        chk("gpio_segment", SEGMENT, 1);

        // Invalid mode keeps the pending request
        req(2, 8'h00, 0); tick();
        req(0, 8'h07, 0); tick();
        chk("err_pulse", ERR, 1);
        chk("err_keeps_pending", PENDING, 1);
        idle(); tick();
        chk("err_clear", ERR, 0);
        IDX_WRAP = 1; tick();
        chk("err_retained_seg", SEGMENT, 2);
        idle(); tick();

        // Overwrite: last writer wins
        req(1, 8'h00, 0); tick();
        req(3, 8'h00, 0); tick();
        idle(); IDX_WRAP = 1; tick();
        chk("overwrite_seg", SEGMENT, 3);
        idle(); tick();

        // Reset mid-pending
        req(1, 8'h01, 64'hFFFF_FFFF_FFFF_0000); tick();
        idle(); tick();
        chk("rst_pre_pending", PENDING, 1);
        RST = 1; #2;
        chk("rst_async_seg", SEGMENT, 0);
        chk("rst_async_flags", {STOP, PENDING, SWAP, ERR}, 0);
        tick();
        RST = 0; tick();

        // Randomized traffic
        REP = '1;
        SYS_TIME = 2000;
        for (int i = 0; i < 3000; i++) begin
            SYS_TIME = SYS_TIME + 1;
            UPDATE = ($urandom_range(0, 7) == 0);
            REQ_RD_SEGMENT = SW'($urandom_range(0, NS - 1));
            case ($urandom_range(0, 4))
                0: TRANSITION_MODE = 8'h00;
                1: TRANSITION_MODE = 8'h01;
                2: TRANSITION_MODE = 8'h02;
                3: TRANSITION_MODE = 8'hFF;
                default: TRANSITION_MODE = 8'($urandom_range(3, 254));
            endcase
            if (TRANSITION_MODE == 8'h01)
                TRANSITION_VALUE = SYS_TIME + 64'($urandom_range(0, 16)) - 64'd4;
            else
                TRANSITION_VALUE = {32'($urandom), 32'($urandom)};
            IDX_WRAP = ($urandom_range(0, 3) == 0);
            GPIO_IN = GW'($urandom);
            if ($urandom_range(0, 31) == 0)
                REP[$urandom_range(0, NS - 1)] = ($urandom_range(0, 3) == 0) ? 16'hFFFF
                                                 : 16'($urandom_range(0, 3));
            RST = ($urandom_range(0, 599) == 0);
            tick();
        end
        RST = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
